// File: rtl/frame_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_load_ctrl: validates one-frame SPI transfers and commits them to    |
// | the register frontend only at a display frame boundary. Rev 1.0           |
// +--------------------------------------------------------------------------+
module frame_load_ctrl #(
  parameter int FRAME_BITS = 256,
  parameter int CNT_W      = 9,
  parameter int ERR_W      = 4,
  parameter int FCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_in,
  input  logic              sck_in,
  input  logic              frame_start,
  output logic              en_load,
  output logic              pending,
  output logic              rx_busy,
  output logic [ERR_W-1:0]  err_count,
  output logic [FCNT_W-1:0] frame_count
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_FRAME  = CNT_W'(FRAME_BITS);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_PEND    = 3'd2,
    ST_PEND_RX = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  // Bits [1:0] are the synchroniser, bit [2] is the edge-detect history.
  logic [2:0]        cs_sync_q;
  logic [2:0]        sck_sync_q;
  logic              cs_s;
  logic              cs_fall;
  logic              cs_rise;
  logic              sck_rise;

  state_t            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ERR_W-1:0]  err_q,    err_d;
  logic [FCNT_W-1:0] fcnt_q,   fcnt_d;
  logic              en_load_q;
  logic              pending_q;
  logic              rx_busy_q;
  logic              frame_ok;
  logic              err_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q  <= 3'b111;
      sck_sync_q <= 3'b000;
    end else begin
      cs_sync_q  <= {cs_sync_q[1:0], cs_in};
      sck_sync_q <= {sck_sync_q[1:0], sck_in};
    end
  end

  assign cs_s     = cs_sync_q[1];
  assign cs_fall  = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise  = ~cs_sync_q[2] & cs_sync_q[1];
  assign sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
  assign frame_ok = (cnt_q == CNT_FRAME);

  // Saturating so an overlong burst can never alias back onto FRAME_BITS.
  always_comb begin
    cnt_d = cnt_q;
    if (cs_fall) begin
      cnt_d = '0;
    end else if (sck_rise && !cs_s && !cs_rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_RX;
      end
      ST_RX, ST_PEND_RX: begin
        if (cs_rise) begin
          if (frame_ok) begin
            state_d = ST_PEND;
          end else begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end
        end
      end
      ST_PEND: begin
        // A new transfer is about to overwrite staging, so it beats the commit.
        if (cs_fall) state_d = ST_PEND_RX;
        else if (frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = cs_fall ? ST_RX : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d  = err_q;
    fcnt_d = fcnt_q;
    if (err_inc && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
    if (state_d == ST_COMMIT) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= '0;
      fcnt_q    <= '0;
      en_load_q <= 1'b0;
      pending_q <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      en_load_q <= (state_d == ST_COMMIT);
      pending_q <= (state_d == ST_PEND) || (state_d == ST_PEND_RX);
      rx_busy_q <= (state_d == ST_RX) || (state_d == ST_PEND_RX);
    end
  end

  assign en_load     = en_load_q;
  assign pending     = pending_q;
  assign rx_busy     = rx_busy_q;
  assign err_count   = err_q;
  assign frame_count = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_load_ctrl: self-checking bench with a frame-level reference     |
// | model of staging, commit and error counting. Rev 1.0                      |
// +--------------------------------------------------------------------------+
module tb_frame_load_ctrl;

  localparam int FB     = 256;
  localparam int ERRMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs_in = 1'b1, sck_in = 1'b0, frame_start = 1'b0;
  logic       en_load, pending, rx_busy;
  logic [3:0] err_count;
  logic [7:0] frame_count;

  logic       cs2 = 1'b1, sck2 = 1'b0, fs2 = 1'b0;
  logic       en2, pend2, busy2;
  logic [3:0] err2;
  logic [7:0] fc2;

  int n_pass = 0, n_tot = 0, n_en = 0, n_en2 = 0;
  bit pend_m = 1'b0;
  int err_m = 0, fcnt_m = 0;
  bit rnd_sck = 1'b0;

  frame_load_ctrl u_dut (
    .clk(clk), .rst(rst), .cs_in(cs_in), .sck_in(sck_in), .frame_start(frame_start),
    .en_load(en_load), .pending(pending), .rx_busy(rx_busy),
    .err_count(err_count), .frame_count(frame_count)
  );

  frame_load_ctrl #(.FRAME_BITS(4), .CNT_W(3), .ERR_W(4), .FCNT_W(8)) u_wrap (
    .clk(clk), .rst(rst), .cs_in(cs2), .sck_in(sck2), .frame_start(fs2),
    .en_load(en2), .pending(pend2), .rx_busy(busy2),
    .err_count(err2), .frame_count(fc2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (en_load) n_en++;
    if (en2) n_en2++;
  end

  // Reference model: a transfer of exactly FB bits stages a frame, anything else
  // drops staging and counts an error; a quiet frame_start commits staging.
  function automatic void model_txn(input int n);
    if (n == FB) begin
      pend_m = 1'b1;
    end else begin
      pend_m = 1'b0;
      if (err_m < ERRMAX) err_m++;
    end
  endfunction

  function automatic bit model_fs();
    bit c;
    c = pend_m;
    if (c) begin
      pend_m = 1'b0;
      fcnt_m = (fcnt_m + 1) % 256;
    end
    return c;
  endfunction

  // mode: 0 none, 1 frame_start on the cs_fall cycle, 2 mid-transfer, 3 on the cs_rise cycle
  task automatic spi_txn(input int nbits, input int mode);
    int hi, lo;
    cs_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (mode == 1) frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      hi = rnd_sck ? int'($urandom_range(1, 2)) : 1;
      lo = rnd_sck ? int'($urandom_range(1, 2)) : 1;
      sck_in = 1'b1;
      if (mode == 2 && i == nbits / 2) frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (hi - 1) @(negedge clk);
      sck_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
    cs_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (mode == 3) frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic fs_pulse(output logic en_now, output logic en_next, output logic pend_now);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    en_now = en_load;
    @(negedge clk);
    en_next  = en_load;
    pend_now = pending;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tot++; if (en_load !== 1'b0) $display("FAIL reset_en_load: got %b want 0", en_load); else n_pass++;
    n_tot++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", pending); else n_pass++;
    n_tot++; if (rx_busy !== 1'b0) $display("FAIL reset_rx_busy: got %b want 0", rx_busy); else n_pass++;
    n_tot++; if (err_count !== 4'd0) $display("FAIL reset_err: got %0d want 0", err_count); else n_pass++;
    n_tot++; if (frame_count !== 8'd0) $display("FAIL reset_fcnt: got %0d want 0", frame_count); else n_pass++;
    rst = 1'b0;
    pend_m = 1'b0; err_m = 0; fcnt_m = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_valid_frame();
    logic a, b, p;
    bit exp;
    spi_txn(FB, 0); model_txn(FB);
    n_tot++; if (pending !== pend_m) $display("FAIL valid_pending: got %b want %b", pending, pend_m); else n_pass++;
    n_tot++; if (rx_busy !== 1'b0) $display("FAIL valid_rx_busy: got %b want 0", rx_busy); else n_pass++;
    exp = model_fs();
    fs_pulse(a, b, p);
    n_tot++; if (a !== exp) $display("FAIL valid_en_load: got %b want %b", a, exp); else n_pass++;
    n_tot++; if (b !== 1'b0) $display("FAIL valid_en_one_cycle: got %b want 0", b); else n_pass++;
    n_tot++; if (p !== 1'b0) $display("FAIL valid_pending_clear: got %b want 0", p); else n_pass++;
    n_tot++; if (frame_count !== 8'(fcnt_m)) $display("FAIL valid_fcnt: got %0d want %0d", frame_count, fcnt_m); else n_pass++;
  endtask

  task automatic test_short();
    logic a, b, p;
    bit exp;
    spi_txn(FB - 1, 0); model_txn(FB - 1);
    n_tot++; if (err_count !== 4'(err_m)) $display("FAIL short_err: got %0d want %0d", err_count, err_m); else n_pass++;
    n_tot++; if ({pending, rx_busy} !== 2'b00) $display("FAIL short_idle: got %b want 00", {pending, rx_busy}); else n_pass++;
    exp = model_fs();
    fs_pulse(a, b, p);
    n_tot++; if (a !== exp) $display("FAIL short_en_load: got %b want %b", a, exp); else n_pass++;
  endtask

  task automatic test_long();
    logic a, b, p;
    bit exp;
    spi_txn(FB + 1, 0); model_txn(FB + 1);
    n_tot++; if (err_count !== 4'(err_m)) $display("FAIL long_err: got %0d want %0d", err_count, err_m); else n_pass++;
    spi_txn(FB, 0); model_txn(FB);
    exp = model_fs();
    fs_pulse(a, b, p);
    n_tot++; if (a !== exp) $display("FAIL long_recover_en: got %b want %b", a, exp); else n_pass++;
    n_tot++; if (frame_count !== 8'(fcnt_m)) $display("FAIL long_fcnt: got %0d want %0d", frame_count, fcnt_m); else n_pass++;
  endtask

  task automatic test_overwrite();
    logic a, b, p;
    bit exp;
    int en0;
    spi_txn(FB, 0); model_txn(FB);
    en0 = n_en;
    spi_txn(FB, 2); model_txn(FB);
    n_tot++; if (n_en !== en0) $display("FAIL ovw_no_midcommit: got %0d want %0d", n_en, en0); else n_pass++;
    n_tot++; if (pending !== pend_m) $display("FAIL ovw_pending: got %b want %b", pending, pend_m); else n_pass++;
    exp = model_fs();
    fs_pulse(a, b, p);
    n_tot++; if (a !== exp) $display("FAIL ovw_en_load: got %b want %b", a, exp); else n_pass++;
    n_tot++; if (n_en !== en0 + 1) $display("FAIL ovw_one_commit: got %0d want %0d", n_en, en0 + 1); else n_pass++;
  endtask

  task automatic test_drop();
    logic a, b, p;
    bit exp;
    spi_txn(FB, 0); model_txn(FB);
    spi_txn(10, 0); model_txn(10);
    n_tot++; if (pending !== pend_m) $display("FAIL drop_pending: got %b want %b", pending, pend_m); else n_pass++;
    n_tot++; if (err_count !== 4'(err_m)) $display("FAIL drop_err: got %0d want %0d", err_count, err_m); else n_pass++;
    exp = model_fs();
    fs_pulse(a, b, p);
    n_tot++; if (a !== exp) $display("FAIL drop_en_load: got %b want %b", a, exp); else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic a, b, p;
    bit exp;
    int en0;
    en0 = n_en;
    spi_txn(FB, 3); model_txn(FB);
    n_tot++; if (n_en !== en0) $display("FAIL rise_fs_commit: got %0d want %0d", n_en, en0); else n_pass++;
    n_tot++; if (pending !== pend_m) $display("FAIL rise_fs_pending: got %b want %b", pending, pend_m); else n_pass++;
    spi_txn(FB, 1); model_txn(FB);
    n_tot++; if (n_en !== en0) $display("FAIL fall_fs_commit: got %0d want %0d", n_en, en0); else n_pass++;
    exp = model_fs();
    fs_pulse(a, b, p);
    n_tot++; if (a !== exp) $display("FAIL same_next_fs_en: got %b want %b", a, exp); else n_pass++;
  endtask

  task automatic test_err_saturate();
    int n;
    for (int i = 0; i < 20; i++) begin
      n = int'($urandom_range(0, 200));
      spi_txn(n, 0); model_txn(n);
      n_tot++; if (err_count !== 4'(err_m)) $display("FAIL errsat_%0d: got %0d want %0d", i, err_count, err_m); else n_pass++;
    end
    n_tot++; if (err_count !== 4'hF) $display("FAIL errsat_final: got %0d want 15", err_count); else n_pass++;
  endtask

  task automatic test_random();
    logic a, b, p;
    bit exp;
    int n, mode, en0;
    rnd_sck = 1'b1;
    for (int i = 0; i < 30; i++) begin
      n    = ($urandom_range(0, 1) == 1) ? FB : int'($urandom_range(FB - 6, FB + 6));
      mode = int'($urandom_range(0, 3));
      en0  = n_en;
      spi_txn(n, mode); model_txn(n);
      n_tot++; if (n_en !== en0) $display("FAIL rnd_txn_commit_%0d: got %0d want %0d", i, n_en, en0); else n_pass++;
      n_tot++; if (pending !== pend_m) $display("FAIL rnd_pending_%0d: got %b want %b", i, pending, pend_m); else n_pass++;
      n_tot++; if (err_count !== 4'(err_m)) $display("FAIL rnd_err_%0d: got %0d want %0d", i, err_count, err_m); else n_pass++;
      if ($urandom_range(0, 2) != 0) begin
        exp = model_fs();
        fs_pulse(a, b, p);
        n_tot++; if (a !== exp) $display("FAIL rnd_en_%0d: got %b want %b", i, a, exp); else n_pass++;
        n_tot++; if (frame_count !== 8'(fcnt_m)) $display("FAIL rnd_fcnt_%0d: got %0d want %0d", i, frame_count, fcnt_m); else n_pass++;
      end
    end
    rnd_sck = 1'b0;
  endtask

  task automatic test_frame_wrap();
    int wrap_m, en0;
    wrap_m = 0;
    en0 = n_en2;
    for (int i = 0; i < 260; i++) begin
      cs2 = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        sck2 = 1'b1; @(negedge clk);
        sck2 = 1'b0; @(negedge clk);
      end
      cs2 = 1'b1;
      repeat (5) @(negedge clk);
      fs2 = 1'b1; @(negedge clk);
      fs2 = 1'b0; @(negedge clk);
      wrap_m = (wrap_m + 1) % 256;
    end
    n_tot++; if (fc2 !== 8'(wrap_m)) $display("FAIL wrap_fcnt: got %0d want %0d", fc2, wrap_m); else n_pass++;
    n_tot++; if (n_en2 - en0 !== 260) $display("FAIL wrap_commits: got %0d want 260", n_en2 - en0); else n_pass++;
    n_tot++; if ({err2, pend2, busy2} !== 6'd0) $display("FAIL wrap_quiet: got %b want 0", {err2, pend2, busy2}); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic a, b, p;
    bit exp;
    spi_txn(FB, 0); model_txn(FB);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n_tot++; if (en_load !== 1'b1) $display("FAIL arst_pre_en: got %b want 1", en_load); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_tot++; if (en_load !== 1'b0) $display("FAIL arst_en_load: got %b want 0", en_load); else n_pass++;
    n_tot++; if (frame_count !== 8'd0) $display("FAIL arst_fcnt: got %0d want 0", frame_count); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    pend_m = 1'b0; err_m = 0; fcnt_m = 0;
    spi_txn(FB - 2, 0); model_txn(FB - 2);
    cs_in = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      sck_in = 1'b1; @(negedge clk);
      sck_in = 1'b0; @(negedge clk);
    end
    n_tot++; if (rx_busy !== 1'b1) $display("FAIL arst_pre_busy: got %b want 1", rx_busy); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_tot++; if (rx_busy !== 1'b0) $display("FAIL arst_rx_busy: got %b want 0", rx_busy); else n_pass++;
    n_tot++; if (err_count !== 4'd0) $display("FAIL arst_err: got %0d want 0", err_count); else n_pass++;
    cs_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend_m = 1'b0; err_m = 0; fcnt_m = 0;
    repeat (4) @(negedge clk);
    spi_txn(FB, 0); model_txn(FB);
    exp = model_fs();
    fs_pulse(a, b, p);
    n_tot++; if (a !== exp) $display("FAIL arst_recover_en: got %b want %b", a, exp); else n_pass++;
    n_tot++; if (frame_count !== 8'(fcnt_m)) $display("FAIL arst_recover_fcnt: got %0d want %0d", frame_count, fcnt_m); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_short();
    test_long();
    test_overwrite();
    test_drop();
    test_same_cycle();
    test_err_saturate();
    test_random();
    test_frame_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
